// File: rtl/rv64g_l2_evict_reader.sv
// rv64g_l2_evict_reader: reads an evicted L2 victim line (tag + data words) from the arrays
// and streams it as Release/ReleaseData beats toward the C-channel formatter.
module rv64g_l2_evict_reader #(
  parameter int WORDS_PER_LINE = 8,
  parameter int DATA_W         = 64,
  parameter int TAG_W          = 50,
  parameter int INDEX_W        = 8,
  parameter int WAY_W          = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               evict_valid_i,
  output logic               evict_ready_o,
  input  logic [INDEX_W-1:0] evict_index_i,
  input  logic [WAY_W-1:0]   evict_way_i,
  input  logic               evict_dirty_i,
  output logic [INDEX_W-1:0] arr_index_o,
  output logic [2:0]         arr_word_sel_o,
  output logic [WAY_W-1:0]   arr_way_sel_o,
  input  logic [DATA_W-1:0]  arr_rdata_i,
  input  logic [TAG_W-1:0]   arr_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [63:0]        out_addr_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               out_has_data_o,
  output logic               out_first_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               done_o
);
  typedef enum logic [1:0] {IDLE, TAG, STREAM} state_e;
  localparam logic [2:0] LAST_IDX = 3'(WORDS_PER_LINE - 1);
  state_e              state_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [WAY_W-1:0]    way_q;
  logic                dirty_q;
  logic [2:0]          cnt_q;
  logic                valid_q, has_q, first_q, last_q, done_q;
  logic [63:0]         addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                hs;
  assign hs             = valid_q & out_ready_i;
  assign evict_ready_o  = state_q == IDLE;
  assign busy_o         = state_q != IDLE;
  assign arr_index_o    = busy_o ? idx_q : '0;
  assign arr_way_sel_o  = busy_o ? way_q : '0;
  assign arr_word_sel_o = state_q == STREAM ? cnt_q : 3'd0;
  assign out_valid_o    = valid_q;
  assign out_addr_o     = addr_q;
  assign out_data_o     = data_q;
  assign out_has_data_o = has_q;
  assign out_first_o    = first_q;
  assign out_last_o     = last_q;
  assign done_o         = done_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      has_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (evict_valid_i) begin
          idx_q   <= evict_index_i;
          way_q   <= evict_way_i;
          dirty_q <= evict_dirty_i;
          state_q <= TAG;
        end
        TAG: begin
          addr_q  <= 64'({arr_tag_i, idx_q, 6'b0});
          first_q <= 1'b1;
          has_q   <= dirty_q;
          data_q  <= dirty_q ? arr_rdata_i : '0;
          last_q  <= !dirty_q || (WORDS_PER_LINE == 1);
          cnt_q   <= 3'd1;
          valid_q <= 1'b1;
          state_q <= STREAM;
        end
        STREAM: if (hs) begin
          if (last_q) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= 3'd0;
            state_q <= IDLE;
          end else begin
            data_q  <= arr_rdata_i;
            first_q <= 1'b0;
            last_q  <= cnt_q == LAST_IDX;
            cnt_q   <= cnt_q == LAST_IDX ? cnt_q : cnt_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv64g_l2_evict_reader.sv
// tb_rv64g_l2_evict_reader: scoreboard bench; stimulus pushes expected beats, a negedge monitor pops them.
module tb_rv64g_l2_evict_reader;
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        hd, f, l;
  } beat_t;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        evict_valid_i = 1'b0, evict_dirty_i = 1'b0, out_ready_i = 1'b1;
  logic [7:0]  evict_index_i = '0;
  logic [3:0]  evict_way_i = '0;
  logic        evict_ready_o, out_valid_o, out_has_data_o, out_first_o, out_last_o, busy_o, done_o;
  logic [7:0]  arr_index_o;
  logic [2:0]  arr_word_sel_o;
  logic [3:0]  arr_way_sel_o;
  logic [63:0] arr_rdata_i, out_addr_o, out_data_o;
  logic [49:0] arr_tag_i;
  logic        rnd_mode = 1'b0, rdy_rand = 1'b0, rdy_val = 1'b1;
  logic [63:0] base_v = '0;
  logic [49:0] tag_v = '0;
  int          checks = 0, errors = 0, lines_acc = 0, lines_done = 0;
  beat_t       q[$];
  rv64g_l2_evict_reader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .evict_valid_i(evict_valid_i), .evict_ready_o(evict_ready_o),
    .evict_index_i(evict_index_i), .evict_way_i(evict_way_i), .evict_dirty_i(evict_dirty_i),
    .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o), .arr_way_sel_o(arr_way_sel_o),
    .arr_rdata_i(arr_rdata_i), .arr_tag_i(arr_tag_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_addr_o(out_addr_o), .out_data_o(out_data_o),
    .out_has_data_o(out_has_data_o), .out_first_o(out_first_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [63:0] mdata(logic [7:0] i, logic [3:0] w, logic [2:0] s);
    return ({49'd0, i, w, s} * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
  endfunction
  function automatic logic [49:0] mtag(logic [7:0] i, logic [3:0] w);
    return 50'({52'd0, i, w} * 64'hC2B2AE3D27D4EB4F);
  endfunction
  assign arr_rdata_i = rnd_mode ? mdata(arr_index_o, arr_way_sel_o, arr_word_sel_o)
                                : base_v + 64'(arr_word_sel_o);
  assign arr_tag_i   = rnd_mode ? mtag(arr_index_o, arr_way_sel_o) : tag_v;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk_i) begin
    #1;
    out_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end
  logic  have_prev = 1'b0, exp_done = 1'b0;
  beat_t prev;
  always @(negedge clk_i) begin
    beat_t e;
    if (!rst_ni) begin
      have_prev = 1'b0;
      exp_done  = 1'b0;
    end else begin
      if (done_o || exp_done) chk("done_pulse", 64'(done_o), 64'(exp_done));
      if (have_prev) begin
        chk("stall_valid", 64'(out_valid_o), 64'd1);
        chk("stall_addr", out_addr_o, prev.addr);
        chk("stall_data", out_data_o, prev.data);
        chk("stall_flags", 64'({out_has_data_o, out_first_o, out_last_o}), 64'({prev.hd, prev.f, prev.l}));
      end
      exp_done = 1'b0;
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("beat_addr", out_addr_o, e.addr);
          chk("beat_data", out_data_o, e.data);
          chk("beat_flags", 64'({out_has_data_o, out_first_o, out_last_o}), 64'({e.hd, e.f, e.l}));
          if (e.l) begin
            lines_done++;
            exp_done = 1'b1;
          end
        end
      end
      have_prev = out_valid_o && !out_ready_i;
      prev = '{out_addr_o, out_data_o, out_has_data_o, out_first_o, out_last_o};
    end
  end
  task automatic issue(input logic [7:0] idx, input logic [3:0] way, input logic dirty, output int waited);
    logic [49:0] t;
    bit acc = 0;
    waited = 0;
    @(posedge clk_i); #1;
    evict_valid_i = 1'b1; evict_index_i = idx; evict_way_i = way; evict_dirty_i = dirty;
    while (!acc && waited < 300) begin
      @(negedge clk_i);
      waited++;
      if (evict_ready_o) acc = 1;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    else begin
      chk("accept_when_idle", 64'(lines_acc - lines_done), 64'd0);
      lines_acc++;
      t = rnd_mode ? mtag(idx, way) : tag_v;
      if (dirty)
        for (int w = 0; w < 8; w++)
          q.push_back('{{t, idx, 6'b0}, rnd_mode ? mdata(idx, way, 3'(w)) : base_v + 64'(w), 1'b1, w == 0, w == 7});
      else q.push_back('{{t, idx, 6'b0}, 64'd0, 1'b0, 1'b1, 1'b1});
    end
    @(posedge clk_i); #1;
    evict_valid_i = 1'b0;
  endtask
  task automatic wait_q(input int n);
    int b = 0;
    do begin
      @(negedge clk_i); #1;
      b++;
    end while (q.size() > n && b < 500);
    if (q.size() > n) chk("wait_queue_timeout", 64'(q.size()), 64'(n));
  endtask
  task automatic profile(input string name, input int busy_exp);
    int nb = 0, nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_i);
      if (i == 0) chk({name, "_valid_tag_cycle"}, 64'(out_valid_o), 64'd0);
      if (i == 1) chk({name, "_valid_first_beat"}, 64'(out_valid_o), 64'd1);
      nb += int'(busy_o);
      nd += int'(done_o);
    end
    chk({name, "_busy_cycles"}, 64'(nb), 64'(busy_exp));
    chk({name, "_done_cycles"}, 64'(nd), 64'd1);
  endtask
  initial begin
    int wt;
    #2;
    @(negedge clk_i);
    chk("rst_ready", 64'(evict_ready_o), 64'd1);
    chk("rst_outs", 64'({out_valid_o, busy_o, done_o, out_has_data_o, out_first_o, out_last_o}), 64'd0);
    chk("rst_addr_data", out_addr_o | out_data_o, 64'd0);
    chk("rst_arr", 64'({arr_index_o, arr_word_sel_o, arr_way_sel_o}), 64'd0);
    @(posedge clk_i); #1; rst_ni = 1'b1;
    // 1: dirty line, ready held high
    base_v = 64'hA0; tag_v = 50'h1234;
    issue(8'h3A, 4'd5, 1'b1, wt);
    profile("t1", 9);
    chk("t1_addr", out_addr_o, 64'h48D_0E80);
    // 2: clean line
    tag_v = 50'h3;
    issue(8'h01, 4'd0, 1'b0, wt);
    profile("t2", 2);
    chk("t2_addr", out_addr_o, 64'hC040);
    // 3: stall beat 2 for three cycles
    base_v = 64'hB0; tag_v = 50'h777;
    issue(8'h10, 4'd2, 1'b1, wt);
    wait_q(6);
    rdy_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t3_word_sel", 64'(arr_word_sel_o), 64'd3);
      chk("t3_stall_data", out_data_o, 64'hB2);
      chk("t3_stall_valid", 64'(out_valid_o), 64'd1);
    end
    rdy_val = 1'b1;
    wait_q(0);
    // 4: request held while busy is only taken once the line has finished
    base_v = 64'hD0; tag_v = 50'h55;
    issue(8'h20, 4'd1, 1'b1, wt);
    issue(8'h21, 4'd3, 1'b1, wt);
    chk("t4_accept_wait", 64'(wt), 64'd9);
    wait_q(0);
    repeat (3) @(posedge clk_i);
    // 5: reset while beat 4 is presented
    base_v = 64'hC0; tag_v = 50'h99;
    issue(8'h44, 4'd7, 1'b1, wt);
    wait_q(4);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    q.delete();
    lines_acc = lines_done;
    @(negedge clk_i);
    chk("t5_valid", 64'(out_valid_o), 64'd0);
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_ready", 64'(evict_ready_o), 64'd1);
    chk("t5_done", 64'(done_o), 64'd0);
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t5_no_done", 64'(done_o), 64'd0);
    // 6: random traffic against the array model
    rnd_mode = 1'b1; rdy_rand = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      issue(8'($urandom), 4'($urandom), 1'($urandom), wt);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end
    wait_q(0);
    rdy_rand = 1'b0; rdy_val = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("t6_lines", 64'(lines_done), 64'(lines_acc));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
